// File: rtl/dmem_port.sv
// dmem_port: data-memory responder for the RV32I pipeline.
// Runs one load and/or store per request on a single-outstanding bus.
//
// Ports
//   CLK, RST_N (async, active-low), FLUSH
//   REQ_*      : ALU-stage request (load addr/strb, store addr/strb/data)
//   STALL      : holds the pipeline (combinational in the accept cycle)
//   LOAD_*     : lane-aligned load result, one-cycle LOAD_VALID in DONE
//   ERR        : one-cycle pulse on misalignment or watchdog expiry
//   MEM_*      : registered valid/ready request bus plus response inputs
//
// Optional feature: define DMEM_TIMEOUT_EN to add the response watchdog
// (TIMEOUT cycles spent waiting for MEM_RESP_VALID).
module dmem_port #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FLUSH,
    input  logic        REQ_VALID,
    input  logic [31:0] REQ_LOAD_ADDR,
    input  logic [3:0]  REQ_LOAD_STRB,
    input  logic [31:0] REQ_STORE_ADDR,
    input  logic [3:0]  REQ_STORE_STRB,
    input  logic [31:0] REQ_STORE_DATA,
    output logic        STALL,
    output logic        LOAD_VALID,
    output logic [31:0] LOAD_DATA,
    output logic [3:0]  LOAD_STRB,
    output logic        ERR,
    output logic        MEM_REQ_VALID,
    input  logic        MEM_REQ_READY,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_RESP_VALID,
    input  logic [31:0] MEM_RDATA
);

    typedef enum logic [2:0] {
        IDLE, ST_REQ, ST_RESP, LD_REQ, LD_RESP, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] ld_addr;
    logic        flushed;
    logic        busy, accept, bad, drop;
    logic        err_nxt, lv_nxt;
    logic        in_resp, wait_expired;
    logic [31:0] ld_src;

    // Shifted mask must stay inside the word; halves also need addr[0]=0.
    function automatic logic misalign(input logic [3:0] s,
                                      input logic [1:0] off);
        logic [7:0] sh;
        sh = {4'b0000, s} << off;
        return (sh[7:4] != 4'b0000) || (s == 4'b0011 && off[0]);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    assign busy    = (state != IDLE) && (state != DONE);
    assign accept  = (state == IDLE) && REQ_VALID && !FLUSH &&
                     ((|REQ_LOAD_STRB) || (|REQ_STORE_STRB));
    assign bad     = misalign(REQ_STORE_STRB, REQ_STORE_ADDR[1:0]) ||
                     misalign(REQ_LOAD_STRB, REQ_LOAD_ADDR[1:0]);
    assign drop    = flushed || FLUSH;
    assign STALL   = accept || busy;
    assign in_resp = (state == ST_RESP) || (state == LD_RESP);
    // A load entered straight from IDLE still reads the live request.
    assign ld_src  = (state == IDLE) ? REQ_LOAD_ADDR : ld_addr;

`ifdef DMEM_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= '0;
        end else if (in_resp) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign wait_expired = in_resp && (wait_cnt == CW'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        lv_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else if (|REQ_STORE_STRB) begin
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = LD_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (MEM_REQ_READY) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (MEM_RESP_VALID) begin
                    state_nxt = ((|LOAD_STRB) && !drop) ? LD_REQ : DONE;
                end else if (wait_expired) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            LD_REQ: begin
                if (MEM_REQ_READY) state_nxt = LD_RESP;
            end
            LD_RESP: begin
                if (MEM_RESP_VALID) begin
                    state_nxt = DONE;
                    lv_nxt    = !drop;
                end else if (wait_expired) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            ld_addr       <= '0;
            flushed       <= 1'b0;
            LOAD_VALID    <= 1'b0;
            LOAD_DATA     <= '0;
            LOAD_STRB     <= '0;
            ERR           <= 1'b0;
            MEM_REQ_VALID <= 1'b0;
            MEM_WE        <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_WSTRB     <= '0;
            MEM_WDATA     <= '0;
        end else begin
            state         <= state_nxt;
            ERR           <= err_nxt;
            LOAD_VALID    <= lv_nxt;
            MEM_REQ_VALID <= (state_nxt == ST_REQ) ||
                             (state_nxt == LD_REQ);
            if (accept) begin
                ld_addr   <= REQ_LOAD_ADDR;
                LOAD_STRB <= REQ_LOAD_STRB;
                flushed   <= 1'b0;
            end else if (busy && FLUSH) begin
                flushed   <= 1'b1;
            end
            if (state == LD_RESP && MEM_RESP_VALID) begin
                LOAD_DATA <= (MEM_RDATA >> {ld_addr[1:0], 3'b000}) &
                             lane_mask(LOAD_STRB);
            end
            // Bus fields load once on entry and stay put while waiting.
            if (state_nxt == ST_REQ && state != ST_REQ) begin
                MEM_WE    <= 1'b1;
                MEM_ADDR  <= {REQ_STORE_ADDR[31:2], 2'b00};
                MEM_WSTRB <= REQ_STORE_STRB << REQ_STORE_ADDR[1:0];
                MEM_WDATA <= REQ_STORE_DATA <<
                             {REQ_STORE_ADDR[1:0], 3'b000};
            end else if (state_nxt == LD_REQ && state != LD_REQ) begin
                MEM_WE    <= 1'b0;
                MEM_ADDR  <= {ld_src[31:2], 2'b00};
                MEM_WSTRB <= 4'b0000;
                MEM_WDATA <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: randomized scoreboard bench for dmem_port.
// Byte-level memory model predicts bus traffic, load data and stall length.
`timescale 1ns/1ps
module tb_dmem_port;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        FLUSH = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic [31:0] REQ_LOAD_ADDR = '0;
    logic [3:0]  REQ_LOAD_STRB = '0;
    logic [31:0] REQ_STORE_ADDR = '0;
    logic [3:0]  REQ_STORE_STRB = '0;
    logic [31:0] REQ_STORE_DATA = '0;
    logic        STALL, LOAD_VALID, ERR;
    logic [31:0] LOAD_DATA;
    logic [3:0]  LOAD_STRB;
    logic        MEM_REQ_VALID;
    logic        MEM_REQ_READY = 1'b0;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic [3:0]  MEM_WSTRB;
    logic        MEM_RESP_VALID = 1'b0;
    logic [31:0] MEM_RDATA = '0;

    dmem_port #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .REQ_VALID(REQ_VALID),
        .REQ_LOAD_ADDR(REQ_LOAD_ADDR), .REQ_LOAD_STRB(REQ_LOAD_STRB),
        .REQ_STORE_ADDR(REQ_STORE_ADDR),
        .REQ_STORE_STRB(REQ_STORE_STRB),
        .REQ_STORE_DATA(REQ_STORE_DATA),
        .STALL(STALL), .LOAD_VALID(LOAD_VALID),
        .LOAD_DATA(LOAD_DATA), .LOAD_STRB(LOAD_STRB), .ERR(ERR),
        .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_READY(MEM_REQ_READY),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WSTRB(MEM_WSTRB),
        .MEM_WDATA(MEM_WDATA), .MEM_RESP_VALID(MEM_RESP_VALID),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          dr;
        int          dp;
        bit          noresp;
    } bus_op_t;

    typedef struct {
        bit          lv;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          err;
        int          stall;
    } exp_t;

    bus_op_t bus_q[$];
    exp_t    exp_q[$];
    int      checks = 0;
    int      failures = 0;

    logic [31:0] bus_mem [int unsigned];
    logic [7:0]  ref_mem [int unsigned];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] word_init(input int unsigned w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [7:0] ref_rd(input int unsigned a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = word_init(a >> 2);
        return w[8*(a%4) +: 8];
    endfunction

    function automatic logic [31:0] bus_rd(input int unsigned w);
        if (bus_mem.exists(w)) return bus_mem[w];
        return word_init(w);
    endfunction

    function automatic int nbytes(input logic [3:0] s);
        case (s)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        bus_mem[a >> 2] = w;
        for (int b = 0; b < 4; b++) ref_mem[a + b] = w[8*b +: 8];
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // fk: -1 no flush, 0 FLUSH in the accept cycle, >0 flush at busy
    // cycle ((fk-1) mod (busy length)) + 1 counted from the accept edge.
    task automatic do_req(
        input logic [31:0] la, input logic [3:0] ls,
        input logic [31:0] sa, input logic [3:0] ss,
        input logic [31:0] sd,
        input int drs, input int dps, input int drl, input int dpl,
        input int fk, input bit noresp);
        int nl, ns, nst, nld, total, fe, cyc, off;
        bit acc, mis, drop;
        exp_t e;
        bus_op_t op;
        nl  = nbytes(ls);
        ns  = nbytes(ss);
        acc = (nl + ns != 0) && (fk != 0);
        fe  = -1;
        if (acc) begin
            mis = (ns != 0 && (sa % ns) != 0) ||
                  (nl != 0 && (la % nl) != 0);
            e.lv = 0; e.data = '0; e.strb = ls; e.err = 0; e.stall = 1;
            if (mis) begin
                e.err = 1;
            end else begin
                nst = (ns != 0) ? drs + dps + 2 : 0;
                nld = (nl == 0) ? 0 :
                      noresp ? drl + 1 + TO : drl + dpl + 2;
                total = 1 + nst + nld;
                if (fk > 0) fe = ((fk - 1) % (total - 1)) + 1;
                drop = (fe > 0) && ns != 0 && nl != 0 && fe <= nst;
                if (ns != 0) begin
                    off = sa % 4;
                    op.addr = sa & ~32'd3; op.we = 1;
                    op.wstrb = '0; op.wdata = '0;
                    op.dr = drs; op.dp = dps; op.noresp = 0;
                    for (int i = 0; i < ns; i++) begin
                        op.wstrb[off + i] = 1'b1;
                        op.wdata[8*(off + i) +: 8] = sd[8*i +: 8];
                        ref_mem[sa + i] = sd[8*i +: 8];
                    end
                    bus_q.push_back(op);
                    e.stall += nst;
                end
                if (nl != 0 && !drop) begin
                    op.addr = la & ~32'd3; op.we = 0;
                    op.wstrb = '0; op.wdata = '0;
                    op.dr = drl; op.dp = dpl; op.noresp = noresp;
                    bus_q.push_back(op);
                    for (int i = 0; i < nl; i++)
                        e.data[8*i +: 8] = ref_rd(la + i);
                    e.stall += nld;
                    if (noresp) e.err = 1;
                    else e.lv = (fe < 0);
                end
            end
            exp_q.push_back(e);
        end
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_LOAD_ADDR = la; REQ_LOAD_STRB = ls;
        REQ_STORE_ADDR = sa; REQ_STORE_STRB = ss;
        REQ_STORE_DATA = sd;
        FLUSH = (fk == 0);
        #1;
        if (!acc) begin
            chk("no_accept_stall", {31'd0, STALL}, 32'd0);
            return;
        end
        chk("accept_stall", {31'd0, STALL}, 32'd1);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            FLUSH = (cyc == fe);
            #1;
        end while (STALL && cyc < 400);
        FLUSH = 1'b0;
        if (STALL) begin
            chk("done_wait_bound", 32'd0, 32'd1);
            finish_now();
        end
    endtask

    // Bus responder: word memory, per-op ready/response delays.
    initial begin : responder
        bus_op_t op;
        int st, cnt;
        logic [31:0] w;
        st = 0; cnt = 0;
        forever begin
            @(negedge CLK);
            MEM_REQ_READY  = 1'b0;
            MEM_RESP_VALID = 1'b0;
            MEM_RDATA      = $urandom;
            if (!RST_N) begin
                st = 0;
                continue;
            end
            if (st == 2) begin
                if (op.noresp) begin
                    st = 0;
                end else if (cnt == op.dp) begin
                    MEM_RESP_VALID = 1'b1;
                    w = bus_rd(op.addr >> 2);
                    if (op.we) begin
                        for (int b = 0; b < 4; b++)
                            if (MEM_WSTRB[b]) w[8*b +: 8] = MEM_WDATA[8*b +: 8];
                        bus_mem[op.addr >> 2] = w;
                    end else begin
                        MEM_RDATA = w;
                    end
                    st = 0;
                end else begin
                    cnt++;
                end
            end else if (st == 0 && MEM_REQ_VALID) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_req", 32'd1, 32'd0);
                    op.addr = MEM_ADDR; op.we = MEM_WE;
                    op.wstrb = MEM_WSTRB; op.wdata = MEM_WDATA;
                    op.dr = 0; op.dp = 0; op.noresp = 0;
                end else begin
                    op = bus_q.pop_front();
                    if (op.we) begin
                        chk("bus_wstrb", {28'd0, MEM_WSTRB},
                            {28'd0, op.wstrb});
                        chk("bus_wdata", MEM_WDATA & lanes(op.wstrb),
                            op.wdata);
                    end
                end
                cnt = 0;
                st  = 1;
            end
            if (st == 1) begin
                chk("bus_valid_hold", {31'd0, MEM_REQ_VALID}, 32'd1);
                chk("bus_addr", MEM_ADDR, op.addr);
                chk("bus_we", {31'd0, MEM_WE}, {31'd0, op.we});
                // Responses outside the response phase must be ignored.
                MEM_RESP_VALID = ($urandom_range(0, 3) == 0);
                if (cnt == op.dr) begin
                    MEM_REQ_READY = 1'b1;
                    st  = 2;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: a STALL fall marks DONE; pop and compare the prediction.
    initial begin : monitor
        bit prev;
        int run;
        exp_t e;
        prev = 0; run = 0;
        forever begin
            @(negedge CLK);
            #1;
            if (!RST_N) begin
                prev = 0; run = 0;
                continue;
            end
            if (prev && !STALL) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_load_valid", {31'd0, LOAD_VALID},
                        {31'd0, e.lv});
                    chk("done_err", {31'd0, ERR}, {31'd0, e.err});
                    chk("done_load_strb", {28'd0, LOAD_STRB},
                        {28'd0, e.strb});
                    chk("stall_cycles", run, e.stall);
                    if (e.lv) chk("load_data", LOAD_DATA, e.data);
                end
            end else begin
                chk("quiet_load_valid", {31'd0, LOAD_VALID}, 32'd0);
                chk("quiet_err", {31'd0, ERR}, 32'd0);
            end
            run  = STALL ? run + 1 : 0;
            prev = STALL;
        end
    end

    function automatic logic [3:0] pick_strb();
        case ($urandom_range(0, 3))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    initial begin : stim
        logic [31:0] la, sa;
        logic [3:0]  ls, ss;
        int fk, n;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_stall", {31'd0, STALL}, 32'd0);
        chk("rst_load_valid", {31'd0, LOAD_VALID}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, MEM_REQ_VALID}, 32'd0);
        chk("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        chk("rst_load_data", LOAD_DATA, 32'd0);
        chk("rst_load_strb", {28'd0, LOAD_STRB}, 32'd0);
        chk("rst_mem_addr", MEM_ADDR, 32'd0);
        chk("rst_mem_wstrb", {28'd0, MEM_WSTRB}, 32'd0);
        chk("rst_mem_wdata", MEM_WDATA, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        poke(32'h100, 32'hDEADBEEF);
        do_req(32'h100, 4'hF, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        do_req(0, 0, 32'h203, 4'h1, 32'h0000005A, 0, 0, 0, 0, -1, 0);
        poke(32'h100, 32'h12345678);
        do_req(32'h102, 4'h3, 0, 0, 0, 0, 0, 3, 0, -1, 0);
        do_req(32'h101, 4'hF, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        do_req(32'h104, 4'hF, 0, 0, 0, 0, 0, 0, 3, 3, 0);
        do_req(32'h100, 4'hF, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        do_req(32'h21, 4'h1, 32'h20, 4'hF, 32'hCAFEF00D,
               0, 0, 0, 0, -1, 0);
        do_req(32'h24, 4'hF, 32'h28, 4'h3, 32'h0000ABCD,
               1, 2, 0, 0, 2, 0);
        do_req(32'h40, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_req(32'h40, 4'h0, 32'h40, 4'h0, 0, 0, 0, 0, 0, -1, 0);
        do_req(0, 0, 32'h32, 4'hF, 32'h11111111, 0, 0, 0, 0, -1, 0);
`ifdef DMEM_TIMEOUT_EN
        do_req(32'h10, 4'hF, 0, 0, 0, 0, 0, 0, 0, -1, 1);
        do_req(32'h14, 4'hF, 0, 0, 0, 0, 0, 0, 0, -1, 0);
`endif

        for (int k = 0; k < 200; k++) begin
            ls = pick_strb();
            ss = pick_strb();
            la = $urandom_range(0, 63);
            sa = $urandom_range(0, 63);
            n = nbytes(ls);
            if (n != 0 && $urandom_range(0, 3) != 0) la = la & ~(n - 1);
            n = nbytes(ss);
            if (n != 0 && $urandom_range(0, 3) != 0) sa = sa & ~(n - 1);
            fk = -1;
            if ($urandom_range(0, 5) == 0) fk = $urandom_range(1, 40);
            else if ($urandom_range(0, 19) == 0) fk = 0;
            do_req(la, ls, sa, ss, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), fk, 0);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                REQ_VALID = 1'b0;
                REQ_LOAD_STRB = pick_strb();
                REQ_STORE_STRB = pick_strb();
            end
        end

        @(negedge CLK);
        REQ_VALID = 1'b0;
        FLUSH = 1'b0;
        repeat (4) @(negedge CLK);
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        chk("sb_queue_drained", exp_q.size(), 32'd0);
        finish_now();
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_time_limit: got expired required finish");
        failures++;
        finish_now();
    end

endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory responder for the RV32I pipeline. Takes the load/store request produced by the ALU stage and performs it on a single-outstanding memory bus. It stalls the pipeline while the access is in flight and returns lane-aligned load data to the memory-read stage. It sits between the ALU stage outputs and the data memory / bus bridge.

## Interface
- `TIMEOUT`, default 255: response watchdog limit in cycles. Used only with `DMEM_TIMEOUT_EN`.
- `CLK` in 1: clock.
- `RST_N` in 1: reset, asynchronous, active-low.
- `FLUSH` in 1: discard the current or pending request result.
- `REQ_VALID` in 1: request inputs are meaningful.
- `REQ_LOAD_ADDR` in 32: load byte address.
- `REQ_LOAD_STRB` in 4: load size mask; 0000 none, 0001 byte, 0011 half, 1111 word.
- `REQ_STORE_ADDR` in 32: store byte address.
- `REQ_STORE_STRB` in 4: store size mask, same encoding as `REQ_LOAD_STRB`.
- `REQ_STORE_DATA` in 32: store data, LSB-justified.
- `STALL` out 1: hold the pipeline.
- `LOAD_VALID` out 1: `LOAD_DATA` valid this cycle.
- `LOAD_DATA` out 32: loaded bytes shifted to bit 0; unused bytes zero.
- `LOAD_STRB` out 4: echo of the accepted load size mask.
- `ERR` out 1: one-cycle pulse on misalignment or timeout.
- `MEM_REQ_VALID` out 1: bus request.
- `MEM_REQ_READY` in 1: bus accepts the request.
- `MEM_WE` out 1: 1 = write.
- `MEM_ADDR` out 32: word-aligned address (`addr[31:2]`, 00).
- `MEM_WSTRB` out 4: byte-lane write strobes.
- `MEM_WDATA` out 32: lane-shifted write data.
- `MEM_RESP_VALID` in 1: write acknowledge or read data valid.
- `MEM_RDATA` in 32: read data, lane-positioned.

## Operation
- **States:** IDLE, ST_REQ, ST_RESP, LD_REQ, LD_RESP, DONE.
- **Accept:** a request is accepted in IDLE when `REQ_VALID`=1, `FLUSH`=0 and either strobe is nonzero.
  - `STALL` goes high combinationally in the accept cycle.
  - All request fields are latched on that cycle's edge.
- **Lane shift:** lane strobe = size mask << `addr[1:0]`.
  - Misaligned if the shifted mask overflows bit 3, or if half-word is used at `addr[0]`=1.
  - On misalignment: no bus access, `ERR` pulses, go to DONE with `LOAD_VALID`=0.
- **Store:** `MEM_WDATA` = data << 8·`addr[1:0]`.
- **Load:** `LOAD_DATA` = (`MEM_RDATA` >> 8·`addr[1:0]`) masked to the size. Sign extension is not done here.
- **Next state from IDLE:** store strobe ≠ 0 goes to ST_REQ; otherwise load goes to LD_REQ.
  - Both strobes nonzero: the store is performed first, then the load (ST_RESP → LD_REQ).
- **xx_REQ:** hold `MEM_REQ_VALID`=1 with stable bus fields until `MEM_REQ_READY`=1, then go to xx_RESP.
- **xx_RESP:** wait for `MEM_RESP_VALID`.
  - ST_RESP goes to LD_REQ if a load is pending, else DONE.
  - LD_RESP captures read data, then goes to DONE.
- **DONE:** `STALL`=0; `LOAD_VALID`=1 for one cycle if a load completed. Always returns to IDLE; requests are never accepted in DONE, because the inputs still hold the consumed instruction.
- **FLUSH while busy:** the bus transaction in flight still completes, since it cannot be aborted.
  - A pending load after a store is dropped.
  - DONE is reached with `LOAD_VALID`=0.
  - `STALL` stays high until DONE.
- **Async reset mid-transaction:** returns to IDLE at once. The bus side is expected to be reset together with this block.

## Timing
- **Reset values:** `STALL`, `LOAD_VALID`, `ERR`, `MEM_REQ_VALID`, `MEM_WE` = 0; `LOAD_DATA`, `LOAD_STRB`, `MEM_ADDR`, `MEM_WSTRB`, `MEM_WDATA` = 0; state = IDLE.
- **Zero-wait memory** (ready and resp in the first cycle offered):
  - single access: accept → REQ → RESP → DONE, 4 cycles, `STALL` high for 3;
  - store+load: 6 cycles, `STALL` high for 5.
- **Misaligned request:** accept → DONE, 2 cycles.
- **Registered outputs:** `MEM_*` outputs are registered from state. `STALL` is the only combinational output (IDLE accept term).
- **Bus protocol:**
  - `MEM_RESP_VALID` outside xx_RESP is ignored.
  - At most one outstanding request.

## Configuration
- **`DMEM_TIMEOUT_EN` defined:** an 8+-bit counter (width from `TIMEOUT`) counts cycles spent in xx_RESP. Reaching `TIMEOUT` causes an `ERR` pulse, a forced jump to DONE, and `LOAD_VALID`=0.
- **Undefined:** no counter; xx_RESP waits indefinitely and `ERR` flags misalignment only.

## Test plan
- Load word at 0x100, zero-wait, `MEM_RDATA`=0xDEADBEEF → `STALL` high 3 cycles; DONE has `LOAD_VALID`=1, `LOAD_DATA`=0xDEADBEEF, `MEM_ADDR`=0x100.
- Store byte 0x5A at 0x203 → `MEM_WSTRB`=1000, `MEM_WDATA`=0x5A000000, `MEM_ADDR`=0x200, `MEM_WE`=1; `LOAD_VALID` stays 0.
- Load half at 0x102, `MEM_REQ_READY` delayed 3 cycles, `MEM_RDATA`=0x12345678 → `MEM_REQ_VALID` and fields stable 4 cycles; `LOAD_DATA`=0x00001234, `STALL` high 6 cycles.
- Load word at 0x101 → `ERR` pulse, no `MEM_REQ_VALID`, DONE after 2 cycles, `LOAD_VALID`=0.
- `FLUSH` pulsed during LD_RESP → response still consumed, DONE has `LOAD_VALID`=0, next `REQ_VALID` is accepted normally.
- With `DMEM_TIMEOUT_EN`, `TIMEOUT`=8, `MEM_RESP_VALID` never asserted → `ERR` 8 cycles after entering LD_RESP, then `STALL` drops.
